memtest_seq: RTL and testbench



---
 rtl/memtest_pkg.sv | 29 ++
 rtl/memtest_seq_timer.sv | 58 +++++
 rtl/memtest_seq.sv | 182 ++++++++++++++++++
 tb/tb_memtest_seq.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memtest_pkg.sv
// Shared types and defaults for the memory-test run controller.
// Holds the sequencer state encoding and the BCD digit helper.
package memtest_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam int DEF_PASS_THRESH = 4;
  localparam int DEF_RST_CYCLES  = 1000000;

  // Returns {carry_out, digit} for a ripple BCD increment.
  function automatic logic [4:0] bcd_inc(
    input bcd_t d,
    input logic ci
  );
    if (!ci)
      return {1'b0, d};
    else if (d == 4'd9)
      return {1'b1, 4'd0};
    else
      return {1'b0, d + 4'd1};
  endfunction

endpackage

// File: rtl/memtest_seq_timer.sv
// Elapsed-time clock: seconds prescaler, binary secs, BCD minutes.
// clr zeroes everything; en lets the prescaler advance.
module bcd_timer
  import memtest_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int MIN_DIGITS    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    en,
  output logic [4*MIN_DIGITS-1:0] mins,
  output logic [5:0]              secs
);

  localparam int PSW =
    TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PSW-1:0] PS_LAST =
    PSW'(TICKS_PER_SEC - 1);

  logic [PSW-1:0]          presc;
  logic                    sec_tick;
  logic                    min_tick;
  logic                    carry;
  logic [4*MIN_DIGITS-1:0] mins_inc;

  assign sec_tick = en && (presc == PS_LAST);
  assign min_tick = sec_tick && (secs == 6'd59);

  always_comb begin
    mins_inc = mins;
    carry    = 1'b1;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      {carry, mins_inc[4*i +: 4]} =
        bcd_inc(mins[4*i +: 4], carry);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      secs  <= '0;
      mins  <= '0;
    end else if (clr) begin
      presc <= '0;
      secs  <= '0;
      mins  <= '0;
    end else if (en) begin
      presc <= sec_tick ? '0 : presc + PSW'(1);
      if (sec_tick)
        secs <= (secs == 6'd59) ? 6'd0 : secs + 6'd1;
      if (min_tick)
        mins <= mins_inc;
    end
  end

endmodule

// File: rtl/memtest_seq.sv
// Run controller: test position, chip, auto sweep and timer.
// Every change goes reconfig request -> tester reset hold -> run.
module memtest_seq
  import memtest_pkg::*;
#(
  parameter int NUM_POS       = 38,
  parameter int NUM_CHIPS     = 3,
  parameter int TICKS_PER_SEC = 50000000,
  parameter int MIN_DIGITS    = 4,
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int PASS_THRESH   = DEF_PASS_THRESH,
  parameter int CNT_W         = 32,
  localparam int PW =
    NUM_POS > 1 ? $clog2(NUM_POS) : 1,
  localparam int CW =
    NUM_CHIPS > 1 ? $clog2(NUM_CHIPS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_down,
  input  logic                    cmd_up,
  input  logic                    cmd_retest,
  input  logic                    cmd_auto,
  input  logic                    cmd_chip,
  input  logic                    cmd_restart,
  input  logic                    recfg_done,
  input  logic [CNT_W-1:0]        passcount,
  input  logic [CNT_W-1:0]        failcount,
  output logic [PW-1:0]           pos,
  output logic [CW-1:0]           chip,
  output logic                    auto_mode,
  output logic                    recfg_req,
  output logic                    tester_rst,
  output logic                    running,
  output logic [4*MIN_DIGITS-1:0] mins,
  output logic [5:0]              secs,
  output logic [PW-1:0]           best_pos,
  output logic                    best_valid
);

  localparam int HW = $clog2(RST_CYCLES + 2);
  localparam logic [PW-1:0] POS_LAST =
    PW'(NUM_POS - 1);
  localparam logic [CW-1:0] CHIP_LAST =
    CW'(NUM_CHIPS - 1);

  state_t         state, state_n;
  logic [HW-1:0]  hold_cnt, hold_n;
  logic [PW-1:0]  pos_n, best_pos_n;
  logic [CW-1:0]  chip_n;
  logic           auto_n, best_valid_n;
  logic           go_req;
  logic           adv_eval;
  logic           fail_hit, pass_hit;

  assign adv_eval = (state == RUN) && auto_mode;
  assign fail_hit = failcount != '0;
  assign pass_hit = passcount >= CNT_W'(PASS_THRESH);

  // Highest asserted command owns the cycle, even when it saturates.
  always_comb begin
    pos_n        = pos;
    chip_n       = chip;
    auto_n       = auto_mode;
    best_pos_n   = best_pos;
    best_valid_n = best_valid;
    go_req       = 1'b0;
    priority case (1'b1)
      cmd_restart: begin
        pos_n        = '0;
        chip_n       = '0;
        auto_n       = 1'b1;
        best_pos_n   = '0;
        best_valid_n = 1'b0;
        go_req       = 1'b1;
      end
      cmd_down: begin
        if (pos != '0) begin
          pos_n  = pos - PW'(1);
          auto_n = 1'b0;
          go_req = 1'b1;
        end
      end
      cmd_up: begin
        if (pos != POS_LAST) begin
          pos_n  = pos + PW'(1);
          auto_n = 1'b0;
          go_req = 1'b1;
        end
      end
      cmd_retest: begin
        auto_n = 1'b0;
        go_req = 1'b1;
      end
      cmd_auto: begin
        pos_n  = '0;
        auto_n = 1'b1;
        go_req = 1'b1;
      end
      cmd_chip: begin
        chip_n = (chip == CHIP_LAST) ? '0 : chip + CW'(1);
        go_req = 1'b1;
      end
      adv_eval: begin
        if (fail_hit) begin
          auto_n = 1'b0;
        end else if (pass_hit) begin
          best_pos_n   = pos;
          best_valid_n = 1'b1;
          if (pos != POS_LAST) begin
            pos_n  = pos + PW'(1);
            go_req = 1'b1;
          end else begin
            auto_n = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    if (go_req) begin
      state_n = REQ;
    end else begin
      case (state)
        REQ: if (recfg_done) begin
          state_n = HOLD;
          hold_n  = HW'(RST_CYCLES);
        end
        HOLD: begin
          if (hold_cnt <= HW'(1))
            state_n = RUN;
          else
            hold_n = hold_cnt - HW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= REQ;
      hold_cnt   <= '0;
      pos        <= '0;
      chip       <= '0;
      auto_mode  <= 1'b1;
      best_pos   <= '0;
      best_valid <= 1'b0;
      recfg_req  <= 1'b1;
      tester_rst <= 1'b1;
      running    <= 1'b0;
    end else begin
      state      <= state_n;
      hold_cnt   <= hold_n;
      pos        <= pos_n;
      chip       <= chip_n;
      auto_mode  <= auto_n;
      best_pos   <= best_pos_n;
      best_valid <= best_valid_n;
      recfg_req  <= state_n == REQ;
      tester_rst <= state_n != RUN;
      running    <= state_n == RUN;
    end
  end

  bcd_timer #(
    .TICKS_PER_SEC (TICKS_PER_SEC),
    .MIN_DIGITS    (MIN_DIGITS)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (state_n != RUN),
    .en    (state == RUN),
    .mins  (mins),
    .secs  (secs)
  );

endmodule

// File: tb/tb_memtest_seq.sv
// Directed bench for memtest_seq: handshake, sweep, commands, timer.
// Instance a covers control; instance t covers the BCD timer.
module tb_memtest_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  logic        a_rst, a_down, a_up, a_retest;
  logic        a_auto, a_chip, a_restart, a_done;
  logic [31:0] a_pass, a_failc;
  logic [5:0]  a_pos, a_best, a_secs;
  logic [1:0]  a_chipo;
  logic        a_am, a_req, a_trst, a_run, a_bv;
  logic [15:0] a_mins;

  logic        t_rst, t_done, t_zero;
  logic [31:0] t_cnt;
  logic [5:0]  t_pos, t_best, t_secs;
  logic [1:0]  t_chipo;
  logic        t_am, t_req, t_trst, t_run, t_bv;
  logic [7:0]  t_mins;

  memtest_seq #(
    .NUM_POS(38), .NUM_CHIPS(3), .TICKS_PER_SEC(20),
    .MIN_DIGITS(4), .RST_CYCLES(10), .PASS_THRESH(4),
    .CNT_W(32)
  ) u_a (
    .clk(clk), .reset(a_rst),
    .cmd_down(a_down), .cmd_up(a_up),
    .cmd_retest(a_retest), .cmd_auto(a_auto),
    .cmd_chip(a_chip), .cmd_restart(a_restart),
    .recfg_done(a_done),
    .passcount(a_pass), .failcount(a_failc),
    .pos(a_pos), .chip(a_chipo), .auto_mode(a_am),
    .recfg_req(a_req), .tester_rst(a_trst),
    .running(a_run), .mins(a_mins), .secs(a_secs),
    .best_pos(a_best), .best_valid(a_bv)
  );

  memtest_seq #(
    .NUM_POS(38), .NUM_CHIPS(3), .TICKS_PER_SEC(2),
    .MIN_DIGITS(2), .RST_CYCLES(2), .PASS_THRESH(4),
    .CNT_W(32)
  ) u_t (
    .clk(clk), .reset(t_rst),
    .cmd_down(t_zero), .cmd_up(t_zero),
    .cmd_retest(t_zero), .cmd_auto(t_zero),
    .cmd_chip(t_zero), .cmd_restart(t_zero),
    .recfg_done(t_done),
    .passcount(t_cnt), .failcount(t_cnt),
    .pos(t_pos), .chip(t_chipo), .auto_mode(t_am),
    .recfg_req(t_req), .tester_rst(t_trst),
    .running(t_run), .mins(t_mins), .secs(t_secs),
    .best_pos(t_best), .best_valid(t_bv)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
  endtask

  task automatic ack_a();
    int w;
    w = 0;
    while (!a_req && w < 50) begin
      tick();
      w++;
    end
    n_run++;
    if (a_req !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_wait req=%b want 1", a_req);
    end
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    w = 0;
    while (!a_run && w < 50) begin
      tick();
      w++;
    end
    n_run++;
    if (a_run !== 1'b1) begin
      n_fail++;
      $display("FAIL run_wait running=%b want 1", a_run);
    end
  endtask

  task automatic test_reset();
    int n;
    tick();
    tick();
    n_run++;
    if ({a_pos, a_chipo, a_am, a_req, a_trst, a_run} !==
        {6'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_ctrl got %h %h %b%b%b%b want 0 0 1110",
               a_pos, a_chipo, a_am, a_req, a_trst, a_run);
    end
    n_run++;
    if ({a_mins, a_secs, a_best, a_bv} !== 29'd0) begin
      n_fail++;
      $display("FAIL rst_misc got %h %h %h %b want 0",
               a_mins, a_secs, a_best, a_bv);
    end
    a_rst = 1'b0;
    repeat (5) tick();
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    n_run++;
    if ({a_req, a_trst} !== 2'b01) begin
      n_fail++;
      $display("FAIL hold_entry req/trst=%b%b want 01",
               a_req, a_trst);
    end
    n = 0;
    while (a_trst && n < 50) begin
      tick();
      n++;
    end
    n_run++;
    if (n != 10) begin
      n_fail++;
      $display("FAIL hold_len got %0d want 10", n);
    end
    n_run++;
    if ({a_run, a_secs} !== {1'b1, 6'd0}) begin
      n_fail++;
      $display("FAIL run_entry run=%b secs=%0d want 1 0",
               a_run, a_secs);
    end
    repeat (19) tick();
    n_run++;
    if (a_secs !== 6'd0) begin
      n_fail++;
      $display("FAIL secs_19 got %0d want 0", a_secs);
    end
    tick();
    n_run++;
    if (a_secs !== 6'd1) begin
      n_fail++;
      $display("FAIL secs_20 got %0d want 1", a_secs);
    end
    n_run++;
    if ({a_pos, a_am} !== {6'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL run_pos got %0d auto=%b want 0 1",
               a_pos, a_am);
    end
  endtask

  task automatic test_sweep();
    reset_a();
    a_pass = 32'd4;
    a_failc = 32'd0;
    for (int p = 0; p < 37; p++) begin
      ack_a();
      tick();
      n_run++;
      if (a_pos !== 6'(p + 1) || a_req !== 1'b1 ||
          a_best !== 6'(p) || a_bv !== 1'b1 ||
          a_am !== 1'b1) begin
        n_fail++;
        $display("FAIL sweep_step p=%0d pos=%0d best=%0d bv=%b req=%b want %0d %0d 1 1",
                 p, a_pos, a_best, a_bv, a_req, p + 1, p);
      end
    end
    ack_a();
    tick();
    n_run++;
    if ({a_pos, a_am, a_best, a_bv} !==
        {6'd37, 1'b0, 6'd37, 1'b1}) begin
      n_fail++;
      $display("FAIL sweep_end pos=%0d auto=%b best=%0d bv=%b want 37 0 37 1",
               a_pos, a_am, a_best, a_bv);
    end
    repeat (3) tick();
    n_run++;
    if ({a_req, a_run} !== 2'b01) begin
      n_fail++;
      $display("FAIL sweep_stay req/run=%b%b want 01",
               a_req, a_run);
    end
    a_pass = 32'd0;
  endtask

  task automatic test_fail();
    reset_a();
    a_pass = 32'd4;
    a_failc = 32'd1;
    ack_a();
    tick();
    n_run++;
    if ({a_pos, a_am, a_bv, a_req} !==
        {6'd0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL fail_p0 pos=%0d auto=%b bv=%b req=%b want 0 0 0 0",
               a_pos, a_am, a_bv, a_req);
    end
    reset_a();
    a_failc = 32'd0;
    for (int p = 0; p < 5; p++) begin
      ack_a();
      tick();
    end
    a_failc = 32'd1;
    ack_a();
    tick();
    n_run++;
    if ({a_pos, a_am, a_best, a_bv} !==
        {6'd5, 1'b0, 6'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL fail_p5 pos=%0d auto=%b best=%0d bv=%b want 5 0 4 1",
               a_pos, a_am, a_best, a_bv);
    end
    repeat (5) tick();
    n_run++;
    if ({a_req, a_run} !== 2'b01) begin
      n_fail++;
      $display("FAIL fail_noreq req/run=%b%b want 01",
               a_req, a_run);
    end
    a_failc = 32'd0;
    a_pass = 32'd0;
    a_auto = 1'b1;
    tick();
    a_auto = 1'b0;
    n_run++;
    if ({a_pos, a_am, a_req, a_best, a_bv} !==
        {6'd0, 1'b1, 1'b1, 6'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL cmd_auto pos=%0d auto=%b req=%b best=%0d bv=%b want 0 1 1 4 1",
               a_pos, a_am, a_req, a_best, a_bv);
    end
    ack_a();
    a_retest = 1'b1;
    tick();
    a_retest = 1'b0;
    n_run++;
    if ({a_pos, a_am, a_req} !== {6'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL retest pos=%0d auto=%b req=%b want 0 0 1",
               a_pos, a_am, a_req);
    end
  endtask

  task automatic test_cmds();
    reset_a();
    ack_a();
    a_down = 1'b1;
    tick();
    a_down = 1'b0;
    n_run++;
    if ({a_req, a_am, a_pos, a_run} !==
        {1'b0, 1'b1, 6'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL down_sat req=%b auto=%b pos=%0d want 0 1 0",
               a_req, a_am, a_pos);
    end
    for (int i = 0; i < 3; i++) begin
      a_up = 1'b1;
      tick();
      a_up = 1'b0;
      n_run++;
      if ({a_pos, a_am, a_req} !==
          {6'(i + 1), 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL up_%0d pos=%0d auto=%b req=%b want %0d 0 1",
                 i, a_pos, a_am, a_req, i + 1);
      end
    end
    a_up = 1'b1;
    a_chip = 1'b1;
    tick();
    a_up = 1'b0;
    a_chip = 1'b0;
    n_run++;
    if ({a_pos, a_chipo, a_am} !== {6'd4, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL up_chip pos=%0d chip=%0d auto=%b want 4 0 0",
               a_pos, a_chipo, a_am);
    end
    for (int i = 0; i < 3; i++) begin
      a_chip = 1'b1;
      tick();
      a_chip = 1'b0;
      n_run++;
      if ({a_chipo, a_req, a_pos} !==
          {2'((i + 1) % 3), 1'b1, 6'd4}) begin
        n_fail++;
        $display("FAIL chip_%0d chip=%0d req=%b pos=%0d want %0d 1 4",
                 i, a_chipo, a_req, a_pos, (i + 1) % 3);
      end
    end
    a_done = 1'b1;
    tick();
    a_done = 1'b0;
    repeat (3) tick();
    a_up = 1'b1;
    tick();
    a_up = 1'b0;
    n_run++;
    if ({a_req, a_trst, a_pos} !== {1'b1, 1'b1, 6'd5}) begin
      n_fail++;
      $display("FAIL up_hold req=%b trst=%b pos=%0d want 1 1 5",
               a_req, a_trst, a_pos);
    end
    repeat (15) tick();
    n_run++;
    if ({a_req, a_trst, a_run} !== 3'b110) begin
      n_fail++;
      $display("FAIL need_ack req/trst/run=%b%b%b want 110",
               a_req, a_trst, a_run);
    end
    a_up = 1'b1;
    a_done = 1'b1;
    tick();
    a_up = 1'b0;
    a_done = 1'b0;
    tick();
    tick();
    n_run++;
    if ({a_req, a_pos} !== {1'b1, 6'd6}) begin
      n_fail++;
      $display("FAIL ack_drop req=%b pos=%0d want 1 6",
               a_req, a_pos);
    end
    ack_a();
    a_down = 1'b1;
    tick();
    a_down = 1'b0;
    n_run++;
    if ({a_pos, a_req} !== {6'd5, 1'b1}) begin
      n_fail++;
      $display("FAIL down pos=%0d req=%b want 5 1",
               a_pos, a_req);
    end
    a_chip = 1'b1;
    tick();
    a_chip = 1'b0;
    a_restart = 1'b1;
    a_down = 1'b1;
    tick();
    a_restart = 1'b0;
    a_down = 1'b0;
    n_run++;
    if ({a_pos, a_chipo, a_am, a_bv, a_req} !==
        {6'd0, 2'd0, 1'b1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL restart pos=%0d chip=%0d auto=%b bv=%b req=%b want 0 0 1 0 1",
               a_pos, a_chipo, a_am, a_bv, a_req);
    end
  endtask

  task automatic test_timer();
    int w;
    t_rst = 1'b0;
    tick();
    t_done = 1'b1;
    tick();
    t_done = 1'b0;
    w = 0;
    while (!t_run && w < 20) begin
      tick();
      w++;
    end
    n_run++;
    if (t_run !== 1'b1) begin
      n_fail++;
      $display("FAIL t_run got %b want 1", t_run);
    end
    repeat (1079) tick();
    n_run++;
    if ({t_mins, t_secs} !== {8'h08, 6'd59}) begin
      n_fail++;
      $display("FAIL t_0859 got %h:%0d want 08:59",
               t_mins, t_secs);
    end
    tick();
    n_run++;
    if ({t_mins, t_secs} !== {8'h09, 6'd0}) begin
      n_fail++;
      $display("FAIL t_09 got %h:%0d want 09:0",
               t_mins, t_secs);
    end
    repeat (120) tick();
    n_run++;
    if ({t_mins, t_secs} !== {8'h10, 6'd0}) begin
      n_fail++;
      $display("FAIL t_10 got %h:%0d want 10:0",
               t_mins, t_secs);
    end
    repeat (10799) tick();
    n_run++;
    if ({t_mins, t_secs} !== {8'h99, 6'd59}) begin
      n_fail++;
      $display("FAIL t_9959 got %h:%0d want 99:59",
               t_mins, t_secs);
    end
    tick();
    n_run++;
    if ({t_mins, t_secs} !== {8'h00, 6'd0}) begin
      n_fail++;
      $display("FAIL t_wrap got %h:%0d want 00:0",
               t_mins, t_secs);
    end
    repeat (7) tick();
    #2;
    t_rst = 1'b1;
    #1;
    n_run++;
    if ({t_pos, t_chipo, t_am, t_req, t_trst, t_run,
         t_mins, t_secs, t_best, t_bv} !==
        {6'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0,
         8'd0, 6'd0, 6'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL t_async pos=%0d am=%b req=%b trst=%b run=%b secs=%0d want 0 1 1 1 0 0",
               t_pos, t_am, t_req, t_trst, t_run, t_secs);
    end
    t_rst = 1'b0;
  endtask

  initial begin
    a_rst = 1'b1;
    a_down = 1'b0;
    a_up = 1'b0;
    a_retest = 1'b0;
    a_auto = 1'b0;
    a_chip = 1'b0;
    a_restart = 1'b0;
    a_done = 1'b0;
    a_pass = 32'd0;
    a_failc = 32'd0;
    t_rst = 1'b1;
    t_done = 1'b0;
    t_zero = 1'b0;
    t_cnt = 32'd0;
    test_reset();
    test_sweep();
    test_fail();
    test_cmds();
    test_timer();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
